// File: rtl/dma_bus_master.sv
`default_nettype none
// ============================================================================
// Module      : dma_bus_master
// Description : Word-copy DMA engine acting as a requester on the picorv32
//               native memory interface. Each word is read from SRC into an
//               internal buffer, then written to DST, with GAP_CYCLES idle
//               cycles between beats. The CPU programs the engine through a
//               small responder-side register port.
//
//               Register map (cfg_addr[3:2]):
//                 0 SRC   source byte address, [1:0] forced to 0
//                 1 DST   destination byte address, [1:0] forced to 0
//                 2 LEN   transfer length in words
//                 3 CTRL  write: bit0 start, bit1 abort
//                   STAT  read : bit0 busy, bit1 done, bit2 aborted,
//                                [31:16] remaining words
//
// Ports       : clk_cpu, resetn (sync, active-low)
//               cfg_*      register access port (responder side)
//               mem_*      native memory interface (requester side)
//               busy       transfer in progress / bus request to arbiter
//               irq_done   one-cycle pulse on normal completion
// Revision    : 1.0 - initial release
// ============================================================================
module dma_bus_master #(
    parameter int LEN_BITS   = 16,
    parameter int GAP_CYCLES = 1
) (
    input  logic        clk_cpu,
    input  logic        resetn,
    input  logic        cfg_valid,
    input  logic [3:0]  cfg_addr,
    input  logic [31:0] cfg_wdata,
    input  logic [3:0]  cfg_wstrb,
    output logic        cfg_ready,
    output logic [31:0] cfg_rdata,
    output logic        mem_valid,
    output logic        mem_instr,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        busy,
    output logic        irq_done
);

    // Gap counter holds GAP_CYCLES-1 down to 0; at least one bit wide.
    localparam int c_GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [c_GAP_W-1:0] c_GAP_LOAD = c_GAP_W'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RD    = 3'd1,
        ST_GAP_W = 3'd2,
        ST_WR    = 3'd3,
        ST_GAP_R = 3'd4
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;

    logic [31:0]           r_src;
    logic [31:0]           r_dst;
    logic [LEN_BITS-1:0]   r_len;
    logic [LEN_BITS-1:0]   r_cnt;
    logic [31:0]           r_buf;
    logic [c_GAP_W-1:0]    r_gap_cnt;
    logic                  r_done;
    logic                  r_aborted;
    logic                  r_abort_pend;
    logic                  r_irq;
    logic                  r_cfg_ready;
    logic [31:0]           r_cfg_rdata;

    logic                  w_idle;
    logic                  w_cfg_acc;
    logic                  w_cfg_wr;
    logic [1:0]            w_sel;
    logic                  w_ctrl_wr;
    logic                  w_abort_cmd;
    logic                  w_start_cmd;
    logic                  w_go;
    logic                  w_zero_done;
    logic                  w_abort;
    logic                  w_beat;
    logic                  w_hs_rd;
    logic                  w_hs_wr;
    logic                  w_last;
    logic [31:0]           w_cnt_ext;
    logic [31:0]           w_stat;
    logic [31:0]           w_rd_mux;
    logic                  w_unused;

    // ------------------------------------------------------------------
    // Config port decode. An access is taken on the cycle where cfg_valid
    // is high and the acknowledge is not already out, so each request is
    // serviced exactly once.
    // ------------------------------------------------------------------
    assign w_idle      = (r_state == ST_IDLE);
    assign w_cfg_acc   = cfg_valid && !r_cfg_ready;
    assign w_cfg_wr    = w_cfg_acc && (cfg_wstrb != 4'h0);
    assign w_sel       = cfg_addr[3:2];
    assign w_ctrl_wr   = w_cfg_wr && (w_sel == 2'd3);
    assign w_abort_cmd = w_ctrl_wr && cfg_wdata[1];
    // Abort in the same write suppresses start; start is ignored while busy.
    assign w_start_cmd = w_ctrl_wr && cfg_wdata[0] && !cfg_wdata[1] && w_idle;
    assign w_go        = w_start_cmd && (r_len != '0);
    assign w_zero_done = w_start_cmd && (r_len == '0);
    // An abort request is remembered until the in-flight beat finishes.
    assign w_abort     = !w_idle && (w_abort_cmd || r_abort_pend);

    assign w_beat      = (r_state == ST_RD) || (r_state == ST_WR);
    assign w_hs_rd     = (r_state == ST_RD) && mem_ready;
    assign w_hs_wr     = (r_state == ST_WR) && mem_ready;
    assign w_last      = (r_cnt == LEN_BITS'(1));

    assign w_cnt_ext   = 32'(r_cnt);
    assign w_stat      = {w_cnt_ext[15:0], 13'd0, r_aborted, r_done, busy};

    always_comb begin
        w_rd_mux = 32'h0;
        case (w_sel)
            2'd0:    w_rd_mux = r_src;
            2'd1:    w_rd_mux = r_dst;
            2'd2:    w_rd_mux = 32'(r_len);
            default: w_rd_mux = w_stat;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_cpu) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state and bus outputs. Bus outputs are decoded purely from
    // registered state, so address/data/strobe cannot change while a beat
    // waits for mem_ready.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        mem_valid   = 1'b0;
        mem_addr    = 32'h0;
        mem_wdata   = 32'h0;
        mem_wstrb   = 4'h0;
        busy        = (r_state != ST_IDLE);
        case (r_state)
            ST_IDLE: begin
                if (w_go) begin
                    w_state_nxt = ST_RD;
                end
            end
            ST_RD: begin
                mem_valid = 1'b1;
                mem_addr  = r_src;
                if (mem_ready) begin
                    w_state_nxt = w_abort ? ST_IDLE : ST_GAP_W;
                end
            end
            ST_GAP_W: begin
                if (w_abort) begin
                    w_state_nxt = ST_IDLE;
                end else if (r_gap_cnt == '0) begin
                    w_state_nxt = ST_WR;
                end
            end
            ST_WR: begin
                mem_valid = 1'b1;
                mem_addr  = r_dst;
                mem_wdata = r_buf;
                mem_wstrb = 4'hF;
                if (mem_ready) begin
                    w_state_nxt = (w_abort || w_last) ? ST_IDLE : ST_GAP_R;
                end
            end
            ST_GAP_R: begin
                if (w_abort) begin
                    w_state_nxt = ST_IDLE;
                end else if (r_gap_cnt == '0) begin
                    w_state_nxt = ST_RD;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers, datapath and status flags
    // ------------------------------------------------------------------
    always_ff @(posedge clk_cpu) begin
        if (!resetn) begin
            r_src        <= 32'h0;
            r_dst        <= 32'h0;
            r_len        <= '0;
            r_cnt        <= '0;
            r_buf        <= 32'h0;
            r_gap_cnt    <= '0;
            r_done       <= 1'b0;
            r_aborted    <= 1'b0;
            r_abort_pend <= 1'b0;
            r_irq        <= 1'b0;
            r_cfg_ready  <= 1'b0;
            r_cfg_rdata  <= 32'h0;
        end else begin
            r_cfg_ready <= w_cfg_acc;
            r_cfg_rdata <= w_cfg_acc ? w_rd_mux : 32'h0;
            r_irq       <= 1'b0;

            // Transfer parameters are frozen for the whole transfer.
            if (w_cfg_wr && w_idle) begin
                case (w_sel)
                    2'd0:    r_src <= {cfg_wdata[31:2], 2'b00};
                    2'd1:    r_dst <= {cfg_wdata[31:2], 2'b00};
                    2'd2:    r_len <= LEN_BITS'(cfg_wdata);
                    default: ;
                endcase
            end

            if (w_go) begin
                r_cnt        <= r_len;
                r_done       <= 1'b0;
                r_aborted    <= 1'b0;
                r_abort_pend <= 1'b0;
            end

            // Zero-length start completes immediately without bus traffic.
            if (w_zero_done) begin
                r_done    <= 1'b1;
                r_aborted <= 1'b0;
                r_irq     <= 1'b1;
            end

            if (w_abort_cmd && !w_idle) begin
                r_abort_pend <= 1'b1;
            end

            // Gap counter reloads on every state change and counts down
            // while the FSM sits in a gap state.
            if (w_state_nxt != r_state) begin
                r_gap_cnt <= c_GAP_LOAD;
            end else if (r_gap_cnt != '0) begin
                r_gap_cnt <= r_gap_cnt - c_GAP_W'(1);
            end

            if (w_hs_rd) begin
                r_buf <= mem_rdata;
                r_src <= r_src + 32'd4;
            end

            if (w_hs_wr) begin
                r_dst <= r_dst + 32'd4;
                r_cnt <= r_cnt - LEN_BITS'(1);
            end

            // Leaving an active state: abort takes precedence over a
            // simultaneous final beat, so an aborted run never reports done.
            if (!w_idle && (w_state_nxt == ST_IDLE)) begin
                r_abort_pend <= 1'b0;
                if (w_abort) begin
                    r_aborted <= 1'b1;
                end else begin
                    r_done <= 1'b1;
                    r_irq  <= 1'b1;
                end
            end
        end
    end

    assign cfg_ready = r_cfg_ready;
    assign cfg_rdata = r_cfg_rdata;
    assign irq_done  = r_irq;
    assign mem_instr = 1'b0;

    // Byte-offset bits of the register address carry no meaning.
    assign w_unused  = ^{cfg_addr[1:0], w_beat};

endmodule
`default_nettype wire

// File: tb/tb_dma_bus_master.sv
`timescale 1ns/1ps
`default_nettype none
module tb_dma_bus_master;

    logic        clk_cpu = 1'b0;
    logic        resetn;
    logic        cfg_valid;
    logic [3:0]  cfg_addr;
    logic [31:0] cfg_wdata;
    logic [3:0]  cfg_wstrb;
    logic        cfg_ready;
    logic [31:0] cfg_rdata;
    logic        mem_valid;
    logic        mem_instr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        busy;
    logic        irq_done;

    always #5 clk_cpu = ~clk_cpu;

    dma_bus_master #(.LEN_BITS(16), .GAP_CYCLES(1)) u_dut (
        .clk_cpu   (clk_cpu),
        .resetn    (resetn),
        .cfg_valid (cfg_valid),
        .cfg_addr  (cfg_addr),
        .cfg_wdata (cfg_wdata),
        .cfg_wstrb (cfg_wstrb),
        .cfg_ready (cfg_ready),
        .cfg_rdata (cfg_rdata),
        .mem_valid (mem_valid),
        .mem_instr (mem_instr),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata),
        .busy      (busy),
        .irq_done  (irq_done)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
    } beat_t;

    beat_t       beats[$];
    logic [31:0] mem [logic [31:0]];

    int n_checks = 0;
    int n_errors = 0;

    // Responder / monitor state
    int   irq_cnt   = 0;
    int   busy_cyc  = 0;
    int   valid_cnt = 0;
    int   unstable  = 0;
    int   withdrawn = 0;
    int   fixed_delay = 0;
    bit   rand_delay  = 0;
    bit   in_beat   = 0;
    int   wait_cnt  = 0;
    int   cur_wait  = 0;
    logic [31:0] hold_addr, hold_wdata;
    logic [3:0]  hold_wstrb;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] init_val(input logic [31:0] a);
        return a * 32'h9E37_79B1 + 32'h1234_5678;
    endfunction

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return init_val(a);
    endfunction

    // Memory responder with programmable wait states, plus event monitors.
    initial begin
        beat_t b;
        mem_ready = 1'b0;
        mem_rdata = 32'h0;
        forever begin
            @(negedge clk_cpu);
            if (irq_done)  irq_cnt++;
            if (busy)      busy_cyc++;
            if (mem_valid) valid_cnt++;
            if (mem_ready) begin
                mem_ready = 1'b0;
                mem_rdata = $urandom;
            end else if (mem_valid) begin
                if (!in_beat) begin
                    in_beat    = 1'b1;
                    wait_cnt   = 0;
                    cur_wait   = rand_delay ? int'($urandom_range(0, 4)) : fixed_delay;
                    hold_addr  = mem_addr;
                    hold_wdata = mem_wdata;
                    hold_wstrb = mem_wstrb;
                end else if (mem_addr !== hold_addr || mem_wdata !== hold_wdata ||
                             mem_wstrb !== hold_wstrb) begin
                    unstable++;
                end
                if (wait_cnt >= cur_wait) begin
                    mem_ready = 1'b1;
                    in_beat   = 1'b0;
                    b.addr    = mem_addr;
                    b.strb    = mem_wstrb;
                    if (mem_wstrb == 4'h0) begin
                        mem_rdata = mem_rd(mem_addr);
                        b.data    = mem_rdata;
                    end else begin
                        mem[mem_addr] = mem_wdata;
                        b.data        = mem_wdata;
                    end
                    beats.push_back(b);
                end else begin
                    wait_cnt++;
                end
            end else if (in_beat) begin
                withdrawn++;
                in_beat = 1'b0;
            end
        end
    end

    task automatic step();
        @(negedge clk_cpu);
        #1;
    endtask

    task automatic cfg_access(input logic [3:0] a, input logic [31:0] d,
                              input logic [3:0] s, output logic [31:0] rd);
        int n;
        step();
        cfg_valid = 1'b1;
        cfg_addr  = a;
        cfg_wdata = d;
        cfg_wstrb = s;
        n = 0;
        do begin
            step();
            n++;
        end while (!cfg_ready && n < 10);
        if (!cfg_ready) check("cfg_ack_timeout", 64'(cfg_ready), 64'd1);
        rd        = cfg_rdata;
        cfg_valid = 1'b0;
        cfg_wstrb = 4'h0;
    endtask

    task automatic cfg_wr(input logic [3:0] a, input logic [31:0] d);
        logic [31:0] rd;
        cfg_access(a, d, 4'hF, rd);
    endtask

    task automatic cfg_rd(input logic [3:0] a, output logic [31:0] rd);
        cfg_access(a, 32'h0, 4'h0, rd);
    endtask

    task automatic wait_idle(input int max_cyc);
        int n = 0;
        while (busy && n < max_cyc) begin
            step();
            n++;
        end
        if (busy) check("idle_timeout", 64'(busy), 64'd0);
    endtask

    task automatic start_copy(input logic [31:0] src, input logic [31:0] dst, input int len);
        beats.delete();
        irq_cnt   = 0;
        busy_cyc  = 0;
        unstable  = 0;
        withdrawn = 0;
        cfg_wr(4'h0, src);
        cfg_wr(4'h4, dst);
        cfg_wr(4'h8, 32'(len));
        cfg_wr(4'hC, 32'h1);
    endtask

    // Expected traffic: read src+4i, then write the same word to dst+4i.
    task automatic verify_copy(input logic [31:0] src, input logic [31:0] dst, input int len);
        logic [31:0] sa, da, rd;
        check("beat_count", 64'(beats.size()), 64'(2 * len));
        for (int i = 0; i < len && (2 * i + 1) < beats.size(); i++) begin
            sa = src + 32'(4 * i);
            da = dst + 32'(4 * i);
            check("rd_addr", 64'(beats[2*i].addr), 64'(sa));
            check("rd_strb", 64'(beats[2*i].strb), 64'h0);
            check("wr_addr", 64'(beats[2*i+1].addr), 64'(da));
            check("wr_strb", 64'(beats[2*i+1].strb), 64'hF);
            check("wr_data", 64'(beats[2*i+1].data), 64'(init_val(sa)));
        end
        check("irq_count", 64'(irq_cnt), 64'd1);
        cfg_rd(4'hC, rd);
        check("stat_done", 64'(rd), 64'h0000_0002);
    endtask

    initial begin
        logic [31:0] rd, src, dst;
        int len, n;

        resetn    = 1'b0;
        cfg_valid = 1'b0;
        cfg_addr  = 4'h0;
        cfg_wdata = 32'h0;
        cfg_wstrb = 4'h0;
        repeat (3) step();
        resetn = 1'b1;

        // Reset state
        check("rst_mem_valid", 64'(mem_valid), 64'd0);
        check("rst_busy",      64'(busy),      64'd0);
        check("rst_irq",       64'(irq_done),  64'd0);
        check("rst_mem_addr",  64'(mem_addr),  64'd0);
        check("rst_mem_instr", 64'(mem_instr), 64'd0);
        for (int r = 0; r < 4; r++) begin
            cfg_rd(4'(r * 4), rd);
            check("rst_reg", 64'(rd), 64'd0);
        end

        // Four-word copy, 3-cycle wait states, register pokes while busy ignored
        fixed_delay = 3;
        rand_delay  = 0;
        start_copy(32'h0010_0000, 32'h1000_0000, 4);
        cfg_wr(4'h0, 32'hDEAD_BEE0);
        cfg_wr(4'h8, 32'h55);
        cfg_wr(4'hC, 32'h1);
        wait_idle(500);
        verify_copy(32'h0010_0000, 32'h1000_0000, 4);
        check("busy_cycles_4w", 64'(busy_cyc), 64'(4 * (2 * 4 + 2) - 1));
        cfg_rd(4'h0, rd);
        check("src_after", 64'(rd), 64'h0010_0010);
        cfg_rd(4'h4, rd);
        check("dst_after", 64'(rd), 64'h1000_0010);
        cfg_rd(4'h8, rd);
        check("len_kept", 64'(rd), 64'd4);

        // Zero-length start
        cfg_wr(4'h8, 32'h0);
        irq_cnt   = 0;
        valid_cnt = 0;
        cfg_wr(4'hC, 32'h1);
        step();
        step();
        check("len0_irq",   64'(irq_cnt),   64'd1);
        check("len0_valid", 64'(valid_cnt), 64'd0);
        check("len0_busy",  64'(busy),      64'd0);
        cfg_rd(4'hC, rd);
        check("len0_stat",  64'(rd), 64'h0000_0002);

        // Long stall: beat must be held stable and never withdrawn
        fixed_delay = 20;
        start_copy(32'h0050_0000, 32'h1200_0000, 1);
        wait_idle(500);
        verify_copy(32'h0050_0000, 32'h1200_0000, 1);
        check("stall_stable",    64'(unstable),  64'd0);
        check("stall_withdrawn", 64'(withdrawn), 64'd0);
        check("stall_cycles",    64'(busy_cyc),  64'(2 * 21 + 2 - 1));

        // Address wrap at the top of memory
        fixed_delay = 1;
        start_copy(32'hFFFF_FFFC, 32'h2000_0000, 2);
        wait_idle(500);
        verify_copy(32'hFFFF_FFFC, 32'h2000_0000, 2);

        // Abort while the first write beat is waiting, LEN=8
        fixed_delay = 6;
        start_copy(32'h0030_0000, 32'h1100_0000, 8);
        n = 0;
        do begin
            step();
            n++;
        end while (!(mem_valid && mem_wstrb == 4'hF) && n < 200);
        if (!(mem_valid && mem_wstrb == 4'hF)) check("abort_wr_timeout", 64'd0, 64'd1);
        cfg_wr(4'hC, 32'h3);
        wait_idle(500);
        check("abort_beats", 64'(beats.size()), 64'd2);
        if (beats.size() >= 2) begin
            check("abort_wr_addr", 64'(beats[1].addr), 64'h1100_0000);
            check("abort_wr_data", 64'(beats[1].data), 64'(init_val(32'h0030_0000)));
        end
        check("abort_irq", 64'(irq_cnt), 64'd0);
        cfg_rd(4'hC, rd);
        check("abort_stat", 64'(rd), 64'h0007_0004);

        // Randomised copies with random wait states per beat
        rand_delay = 1;
        for (int t = 0; t < 6; t++) begin
            src = 32'h0010_0000 + (32'($urandom_range(0, 4095)) << 2);
            dst = 32'h1400_0000 + 32'(t * 32'h1000);
            len = int'($urandom_range(1, 6));
            start_copy(src, dst, len);
            wait_idle(1000);
            verify_copy(src, dst, len);
            check("rand_stable", 64'(unstable), 64'd0);
        end
        rand_delay = 0;

        // Reset during a read with mem_ready pending
        fixed_delay = 5;
        start_copy(32'h0040_0000, 32'h1300_0000, 4);
        n = 0;
        while (!(mem_ready && mem_valid && mem_wstrb == 4'h0) && n < 100) begin
            step();
            n++;
        end
        if (!(mem_ready && mem_valid)) check("rst_rd_timeout", 64'd0, 64'd1);
        resetn = 1'b0;
        step();
        check("midrst_valid", 64'(mem_valid), 64'd0);
        check("midrst_busy",  64'(busy),      64'd0);
        resetn = 1'b1;
        for (int r = 0; r < 4; r++) begin
            cfg_rd(4'(r * 4), rd);
            check("midrst_reg", 64'(rd), 64'd0);
        end
        check("midrst_irq", 64'(irq_cnt), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
